read_store: RTL and testbench

Read store and query responder for the SMEM pipeline, on the far side of the queue's new-read and query interfaces. It does four things:
- accepts reads from the host loader as a stream of 4-bit bases;
- assigns read numbers sequentially;
- hands the queue one new read at a time, with the initial bi-interval computed from the first base;
- answers per-base query lookups with a fixed 3-cycle latency.

---
 rtl/read_store.sv | 180 ++++++++++++++++++
 tb/tb_read_store.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_store.sv
// Read store and query responder for the SMEM pipeline: buffers a batch of reads,
// presents them one at a time with their initial bi-interval, and answers base lookups.
module read_store #(
    parameter int unsigned MAX_READS = 1024,
    parameter int unsigned READ_LEN  = 101
) (
    input  logic        Clk_32UI,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  load_base,
    input  logic        load_last,
    input  logic        load_end,
    input  logic        batch_restart,
    output logic        load_overflow,
    input  logic [63:0] L2_0,
    input  logic [63:0] L2_1,
    input  logic [63:0] L2_2,
    input  logic [63:0] L2_3,
    input  logic [63:0] L2_4,
    input  logic        new_read,
    output logic        new_read_valid,
    output logic        load_done,
    output logic [9:0]  new_read_num,
    output logic [63:0] new_ik_x0,
    output logic [63:0] new_ik_x1,
    output logic [63:0] new_ik_x2,
    output logic [63:0] new_ik_info,
    output logic [6:0]  new_forward_i,
    input  logic [7:0]  query_position_2RAM,
    input  logic [9:0]  query_read_num_2RAM,
    input  logic [5:0]  query_status_2RAM,
    output logic [7:0]  new_read_query_2Queue
);

    localparam logic [7:0]  LEN_MAX = 8'(READ_LEN);
    localparam logic [10:0] CNT_MAX = 11'(MAX_READS);

    typedef enum logic [1:0] {LOAD, FETCH, PRESENT, DRAINED} state_t;
    state_t state, state_next;

    logic [3:0]  base_ram  [MAX_READS*128];
    logic [7:0]  len_ram   [MAX_READS];
    logic [3:0]  first_ram [MAX_READS];

    logic [10:0] read_count, issue_ptr, fetch_addr;
    logic [7:0]  pos, len_after;
    logic        beat_take, base_we, pop;
    logic [3:0]  fb_rd, q_base;
    logic [7:0]  q_len, q_pos, q_res;
    logic        q_bubble, q_inrange;
    logic [63:0] l2 [5];
    logic [63:0] hx0, hx1, hx2;
    logic [2:0]  i0, i1, i3;
    logic        unused_bits;

    assign unused_bits = ^query_status_2RAM[3:0];

    assign load_ready = (state == LOAD) && (read_count < CNT_MAX) && !reset;
    assign beat_take  = load_valid && load_ready && !load_end && !batch_restart;
    assign base_we    = beat_take && (pos < LEN_MAX);
    assign len_after  = (pos < LEN_MAX) ? pos + 8'd1 : LEN_MAX;
    assign pop        = (state == PRESENT) && new_read && !batch_restart;
    // Address the next head ahead of the pop so FETCH sees fresh data.
    assign fetch_addr = pop ? issue_ptr + 11'd1 : issue_ptr;

    always_ff @(posedge Clk_32UI) begin
        if (base_we) begin
            base_ram[{read_count[9:0], pos[6:0]}] <= load_base;
            if (pos == 8'd0)
                first_ram[read_count[9:0]] <= load_base;
        end
        if (beat_take && load_last)
            len_ram[read_count[9:0]] <= len_after;
        fb_rd  <= first_ram[fetch_addr[9:0]];
        q_base <= base_ram[{query_read_num_2RAM, query_position_2RAM[6:0]}];
        q_len  <= len_ram[query_read_num_2RAM];
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset || batch_restart) begin
            read_count    <= '0;
            issue_ptr     <= '0;
            pos           <= '0;
            load_overflow <= 1'b0;
        end else begin
            if (beat_take) begin
                if (pos >= LEN_MAX)
                    load_overflow <= 1'b1;
                if (load_last) begin
                    read_count <= read_count + 11'd1;
                    pos        <= '0;
                end else if (pos < LEN_MAX) begin
                    pos <= pos + 8'd1;
                end
            end
            if (pop)
                issue_ptr <= issue_ptr + 11'd1;
        end
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (batch_restart) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (load_end) state_next = (read_count != '0) ? FETCH : DRAINED;
                FETCH:   state_next = PRESENT;
                PRESENT: if (new_read) state_next = (issue_ptr + 11'd1 == read_count) ? DRAINED : FETCH;
                DRAINED: state_next = DRAINED;
                default: state_next = LOAD;
            endcase
        end
    end

    always_comb begin
        new_read_valid = (state == PRESENT);
        load_done      = (state != LOAD);
        new_forward_i  = '0;
    end

    always_comb begin
        l2[0] = L2_0; l2[1] = L2_1; l2[2] = L2_2; l2[3] = L2_3; l2[4] = L2_4;
        i0  = {1'b0, fb_rd[1:0]};
        i1  = i0 + 3'd1;
        i3  = 3'd3 - i0;
        hx0 = '0;
        hx1 = '0;
        hx2 = '0;
        if (fb_rd[3:2] == 2'b00) begin
            hx0 = l2[i0] + 64'd1;
            hx1 = l2[i3] + 64'd1;
            hx2 = l2[i1] - l2[i0];
        end
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset) begin
            new_read_num <= '0;
            new_ik_x0    <= '0;
            new_ik_x1    <= '0;
            new_ik_x2    <= '0;
            new_ik_info  <= '0;
        end else if (state == FETCH && !batch_restart) begin
            new_read_num <= issue_ptr[9:0];
            new_ik_x0    <= hx0;
            new_ik_x1    <= hx1;
            new_ik_x2    <= hx2;
            new_ik_info  <= 64'd1;
        end
    end

    always_ff @(posedge Clk_32UI) begin
        if (reset) begin
            q_bubble              <= 1'b0;
            q_inrange             <= 1'b0;
            q_pos                 <= '0;
            q_res                 <= '0;
            new_read_query_2Queue <= '0;
        end else begin
            q_bubble  <= (query_status_2RAM[5:4] == 2'b11);
            q_inrange <= ({1'b0, query_read_num_2RAM} < read_count);
            q_pos     <= query_position_2RAM;
            if (q_bubble)
                q_res <= 8'hFF;
            else if (!q_inrange || q_pos >= q_len)
                q_res <= 8'h04;
            else
                q_res <= {4'b0, q_base};
            new_read_query_2Queue <= q_res;
        end
    end

endmodule

// File: tb/tb_read_store.sv
// Self-checking bench for read_store: load/issue sequencing, head intervals,
// pipelined query responder, overflow, empty batch and mid-flight reset.
module tb_read_store;

    localparam int unsigned MAXR = 1024;
    localparam int unsigned RLEN = 101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0, load_ready, load_last = 1'b0, load_end = 1'b0;
    logic [3:0]  load_base = '0;
    logic        batch_restart = 1'b0, load_overflow;
    logic [63:0] L2_0 = 64'd0, L2_1 = 64'd10, L2_2 = 64'd20, L2_3 = 64'd30, L2_4 = 64'd40;
    logic        new_read = 1'b0, new_read_valid, load_done;
    logic [9:0]  new_read_num;
    logic [63:0] new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info;
    logic [6:0]  new_forward_i;
    logic [7:0]  query_position_2RAM = '0;
    logic [9:0]  query_read_num_2RAM = '0;
    logic [5:0]  query_status_2RAM = 6'h30;
    logic [7:0]  new_read_query_2Queue;

    always #5 clk = ~clk;

    read_store #(.MAX_READS(MAXR), .READ_LEN(RLEN)) dut (
        .Clk_32UI(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_base(load_base),
        .load_last(load_last), .load_end(load_end), .batch_restart(batch_restart),
        .load_overflow(load_overflow),
        .L2_0(L2_0), .L2_1(L2_1), .L2_2(L2_2), .L2_3(L2_3), .L2_4(L2_4),
        .new_read(new_read), .new_read_valid(new_read_valid), .load_done(load_done),
        .new_read_num(new_read_num), .new_ik_x0(new_ik_x0), .new_ik_x1(new_ik_x1),
        .new_ik_x2(new_ik_x2), .new_ik_info(new_ik_info), .new_forward_i(new_forward_i),
        .query_position_2RAM(query_position_2RAM), .query_read_num_2RAM(query_read_num_2RAM),
        .query_status_2RAM(query_status_2RAM), .new_read_query_2Queue(new_read_query_2Queue)
    );

    int passed = 0;
    int total  = 0;

    // reference model of the stored batch
    int         m_cnt = 0;
    int         m_pos = 0;
    int         m_len [16];
    logic [3:0] m_base [16][128];

    int         qr [$];
    int         qp [$];
    logic [5:0] qs [$];
    logic [7:0] sb [$];

    function automatic logic [7:0] model_query(int rn, int p, logic [5:0] st);
        if (st[5:4] == 2'b11) return 8'hFF;
        if (rn >= m_cnt) return 8'h04;
        if (p >= m_len[rn]) return 8'h04;
        return {4'b0, m_base[rn][p]};
    endfunction

    function automatic void head_model(input logic [3:0] c, output logic [63:0] a,
                                       output logic [63:0] b, output logic [63:0] d);
        logic [63:0] t [5];
        t[0] = L2_0; t[1] = L2_1; t[2] = L2_2; t[3] = L2_3; t[4] = L2_4;
        a = 0; b = 0; d = 0;
        if (c < 4) begin
            a = t[c] + 1;
            b = t[3 - c] + 1;
            d = t[c + 1] - t[c];
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [3:0] b, input logic last);
        load_valid = 1'b1; load_base = b; load_last = last;
        if (m_pos < RLEN) begin
            m_base[m_cnt][m_pos] = b;
            m_pos++;
        end
        if (last) begin
            m_len[m_cnt] = m_pos;
            m_cnt++;
            m_pos = 0;
        end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic restart();
        batch_restart = 1'b1;
        tick();
        batch_restart = 1'b0;
        m_cnt = 0; m_pos = 0;
    endtask

    task automatic end_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic pop();
        new_read = 1'b1;
        tick();
        new_read = 1'b0;
    endtask

    task automatic add_q(input int rn, input int p, input logic [5:0] st);
        qr.push_back(rn); qp.push_back(p); qs.push_back(st);
    endtask

    task automatic run_queries();
        int n;
        logic [7:0] e;
        n = qr.size();
        for (int c = 0; c < n + 3; c++) begin
            if (c >= 3) begin
                e = sb.pop_front();
                total++;
                if (new_read_query_2Queue !== e)
                    $display("FAIL query[%0d]: got %h expected %h", c - 3, new_read_query_2Queue, e);
                else passed++;
            end
            if (c < n) begin
                query_read_num_2RAM = 10'(qr[c]);
                query_position_2RAM = 8'(qp[c]);
                query_status_2RAM   = qs[c];
                sb.push_back(model_query(qr[c], qp[c], qs[c]));
            end else begin
                query_status_2RAM = 6'h30;
            end
            tick();
        end
        qr.delete(); qp.delete(); qs.delete();
    endtask

    task automatic check_head(input string nm, input int num, input logic [3:0] c);
        logic [63:0] a, b, d;
        head_model(c, a, b, d);
        total++;
        if (new_read_valid !== 1'b1 || new_read_num !== 10'(num) || new_ik_x0 !== a ||
            new_ik_x1 !== b || new_ik_x2 !== d || new_ik_info !== 64'd1 || new_forward_i !== 7'd0)
            $display("FAIL %s: valid=%b num=%0d x0=%0d x1=%0d x2=%0d info=%0d fwd=%0d expected valid=1 num=%0d x0=%0d x1=%0d x2=%0d info=1 fwd=0",
                     nm, new_read_valid, new_read_num, new_ik_x0, new_ik_x1, new_ik_x2,
                     new_ik_info, new_forward_i, num, a, b, d);
        else passed++;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if (load_ready !== 1'b0 || load_overflow !== 1'b0 || new_read_valid !== 1'b0 ||
            load_done !== 1'b0 || new_read_num !== '0 || new_ik_x0 !== '0 || new_ik_x1 !== '0 ||
            new_ik_x2 !== '0 || new_ik_info !== '0 || new_forward_i !== '0 ||
            new_read_query_2Queue !== 8'h00)
            $display("FAIL reset_values: ready=%b ovf=%b valid=%b done=%b info=%0d q=%h expected all zero",
                     load_ready, load_overflow, new_read_valid, load_done, new_ik_info, new_read_query_2Queue);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (load_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", load_ready);
        else passed++;
    endtask

    task automatic test_load_issue();
        send_beat(4'd1, 1'b0); send_beat(4'd2, 1'b0); send_beat(4'd0, 1'b1);
        send_beat(4'd3, 1'b0); send_beat(4'd1, 1'b1);
        end_load();
        total++;
        if (new_read_valid !== 1'b0 || load_done !== 1'b1)
            $display("FAIL fetch_cycle: valid=%b done=%b expected valid=0 done=1", new_read_valid, load_done);
        else passed++;
        tick();
        check_head("head_read0", 0, 4'd1);
        pop();
        total++;
        if (new_read_valid !== 1'b0) $display("FAIL pop_gap: valid=%b expected 0", new_read_valid);
        else passed++;
        tick();
        check_head("head_read1", 1, 4'd3);
        pop();
        tick(); tick(); tick();
        total++;
        if (new_read_valid !== 1'b0 || load_done !== 1'b1 || load_ready !== 1'b0)
            $display("FAIL drained: valid=%b done=%b ready=%b expected 0 1 0",
                     new_read_valid, load_done, load_ready);
        else passed++;
    endtask

    task automatic test_query();
        add_q(0, 1, 6'd1); add_q(0, 0, 6'd0); add_q(0, 2, 6'd2); add_q(1, 0, 6'd0);
        add_q(1, 1, 6'd0); add_q(1, 2, 6'd0); add_q(5, 0, 6'd0); add_q(0, 1, 6'b110000);
        run_queries();
    endtask

    task automatic test_overflow();
        restart();
        total++;
        if (load_overflow !== 1'b0 || load_ready !== 1'b1 || load_done !== 1'b0)
            $display("FAIL restart: ovf=%b ready=%b done=%b expected 0 1 0", load_overflow, load_ready, load_done);
        else passed++;
        for (int i = 0; i < 103; i++)
            send_beat(4'((i + 1) % 4), (i == 102));
        total++;
        if (load_overflow !== 1'b1) $display("FAIL overflow_flag: got %b expected 1", load_overflow);
        else passed++;
        send_beat(4'd4, 1'b0); send_beat(4'd2, 1'b1);
        end_load();
        tick();
        check_head("head_long_read", 0, 4'd1);
        pop(); tick();
        check_head("head_n_base", 1, 4'd4);
        add_q(0, 100, 6'd0); add_q(0, 101, 6'd0); add_q(0, 0, 6'd0);
        add_q(1, 0, 6'd0); add_q(1, 1, 6'd0); add_q(1, 2, 6'd0);
        run_queries();
    endtask

    task automatic test_zero_reads();
        bit seen;
        restart();
        end_load();
        total++;
        if (load_done !== 1'b1) $display("FAIL zero_reads_done: got %b expected 1", load_done);
        else passed++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (new_read_valid) seen = 1;
            tick();
        end
        total++;
        if (seen) $display("FAIL zero_reads_valid: got 1 expected 0");
        else passed++;
    endtask

    task automatic test_reset_midflight();
        restart();
        send_beat(4'd2, 1'b1);
        end_load();
        tick();
        check_head("head_before_reset", 0, 4'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cnt = 0; m_pos = 0;
        #1;
        total++;
        if (new_read_valid !== 1'b0 || load_ready !== 1'b1 || load_done !== 1'b0 || new_ik_info !== '0)
            $display("FAIL reset_midflight: valid=%b ready=%b done=%b info=%0d expected 0 1 0 0",
                     new_read_valid, load_ready, load_done, new_ik_info);
        else passed++;
        tick();
        add_q(0, 0, 6'd0);
        run_queries();
    endtask

    initial begin
        test_reset();
        test_load_issue();
        test_query();
        test_overflow();
        test_zero_reads();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
